// File: rtl/seq_det_pkg.sv
// Elaboration-time helpers for the parametrised sequence detector.
// Patterns are passed zero-extended to 16 bits, first-received bit at index len-1.
package seq_det_pkg;

    function automatic int state_w(input int len);
        int w;
        w = $clog2(len);
        return (w < 1) ? 1 : w;
    endfunction

    // KMP step: longest pattern prefix that is a suffix of prefix(k) followed by b.
    // Capped below len so a full match never appears as a state.
    function automatic int next_prefix(input logic [15:0] pattern, input int len,
                                       input int k, input logic b);
        int  result;
        int  top;
        int  p;
        logic ok;
        logic c;
        result = 0;
        top = (k + 1 < len) ? k + 1 : len - 1;
        for (int j = 1; j <= top; j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                p = k + 1 - j + i;
                c = (p == k) ? b : pattern[len - 1 - p];
                if (c != pattern[len - 1 - i]) ok = 1'b0;
            end
            if (ok) result = j;
        end
        return result;
    endfunction

    function automatic int border_len(input logic [15:0] pattern, input int len);
        int  result;
        logic ok;
        result = 0;
        for (int j = 1; j < len; j++) begin
            ok = 1'b1;
            for (int i = 0; i < j; i++) begin
                if (pattern[len - 1 - i] != pattern[j - 1 - i]) ok = 1'b0;
            end
            if (ok) result = j;
        end
        return result;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detect_fsm.sv
// Mealy detector for a PATTERN_LEN-bit pattern, MSB received first, with
// run-time overlap selection and a saturating hit counter.
//
//   state            | meaning
//   0                | no pattern prefix matched
//   k (1..LEN-1)     | last k accepted bits equal the first k pattern bits
//   >= PATTERN_LEN   | unreachable encoding, recovers to 0 with y low
module seq_detect_fsm
    import seq_det_pkg::*;
#(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
    parameter int                     CNT_W       = 8,
    localparam int                    STATE_W     = state_w(PATTERN_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               x,
    input  logic               x_valid,
    input  logic               overlap,
    input  logic               clear,
    output logic               y,
    output logic [CNT_W-1:0]   hit_count,
    output logic [STATE_W-1:0] currentState,
    output logic [STATE_W-1:0] nextState
);

    localparam int                 NSTATES = 1 << STATE_W;
    localparam logic [STATE_W-1:0] LAST    = STATE_W'(PATTERN_LEN - 1);
    localparam logic [STATE_W-1:0] BORDER  = STATE_W'(border_len(16'(PATTERN), PATTERN_LEN));

    generate
        if (PATTERN_LEN < 2 || PATTERN_LEN > 16 || CNT_W < 1 || CNT_W > 32) begin : g_bad_param
            $error("seq_detect_fsm: PATTERN_LEN must be 2..16 and CNT_W 1..32");
        end
    endgenerate

    logic [STATE_W-1:0] nxt0 [NSTATES];
    logic [STATE_W-1:0] nxt1 [NSTATES];
    logic [NSTATES-1:0] legal;
    logic               hit;

    // Transition table is pure wiring to constants; nothing stored at run time.
    generate
        for (genvar k = 0; k < NSTATES; k++) begin : g_tab
            if (k < PATTERN_LEN) begin : g_legal
                localparam int N0 = next_prefix(16'(PATTERN), PATTERN_LEN, k, 1'b0);
                localparam int N1 = next_prefix(16'(PATTERN), PATTERN_LEN, k, 1'b1);
                assign nxt0[k]  = STATE_W'(N0);
                assign nxt1[k]  = STATE_W'(N1);
                assign legal[k] = 1'b1;
            end else begin : g_illegal
                assign nxt0[k]  = '0;
                assign nxt1[k]  = '0;
                assign legal[k] = 1'b0;
            end
        end
    endgenerate

    assign hit = (currentState == LAST) && (x == PATTERN[0]);

    always_ff @(posedge clk) begin
        if (!reset) begin
            currentState <= '0;
        end else begin
            currentState <= nextState;
        end
    end

    always_comb begin
        nextState = currentState;
        if (!reset || clear) begin
            nextState = '0;
        end else if (x_valid) begin
            if (!legal[currentState]) begin
                nextState = '0;
            end else if (hit) begin
                nextState = overlap ? BORDER : '0;
            end else begin
                nextState = x ? nxt1[currentState] : nxt0[currentState];
            end
        end
    end

    always_comb begin
        y = x_valid & hit & reset & ~clear;
    end

    sat_counter #(
        .W(CNT_W)
    ) u_hits (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .inc   (y),
        .count (hit_count)
    );

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Bench for seq_detect_fsm: three parameterisations share one stimulus stream,
// each checked against a bit-history reference model.
module tb_seq_detect_fsm;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic x = 1'b0;
    logic x_valid = 1'b0;
    logic overlap = 1'b1;
    logic clear = 1'b0;

    logic       y_a, y_b, y_c;
    logic [7:0] hc_a, hc_c;
    logic [1:0] hc_b;
    logic [1:0] cs_a, ns_a, cs_b, ns_b, cs_c, ns_c;

    int errors = 0;
    int checks = 0;

    seq_detect_fsm #(.PATTERN_LEN(4), .PATTERN(4'b1011), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .overlap(overlap), .clear(clear),
        .y(y_a), .hit_count(hc_a), .currentState(cs_a), .nextState(ns_a));

    seq_detect_fsm #(.PATTERN_LEN(4), .PATTERN(4'b1011), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .overlap(overlap), .clear(clear),
        .y(y_b), .hit_count(hc_b), .currentState(cs_b), .nextState(ns_b));

    seq_detect_fsm #(.PATTERN_LEN(3), .PATTERN(3'b111), .CNT_W(8)) dut_c (
        .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .overlap(overlap), .clear(clear),
        .y(y_c), .hit_count(hc_c), .currentState(cs_c), .nextState(ns_c));

    always #5 clk = ~clk;

    // Reference: history of accepted bits, newest in bit 0.
    logic [15:0] m_pat [3] = '{16'hB, 16'hB, 16'h7};
    int          m_len [3] = '{4, 4, 3};
    int          m_max [3] = '{255, 3, 255};
    logic [31:0] m_h   [3];
    int          m_hl  [3];
    int          m_cnt [3];
    int          e_y   [3];
    int          e_ns  [3];

    function automatic logic ends_with(input logic [31:0] h, input int hl,
                                       input logic [15:0] pat, input int len, input int j);
        logic [31:0] mask;
        logic [31:0] pre;
        mask = (32'd1 << j) - 32'd1;
        pre  = 32'(pat) >> (len - j);
        return (hl >= j) && (((h ^ pre) & mask) == 32'd0);
    endfunction

    function automatic int model_state(input logic [31:0] h, input int hl,
                                       input logic [15:0] pat, input int len);
        int r;
        r = 0;
        for (int j = 1; j < len; j++) begin
            if (ends_with(h, hl, pat, len, j)) r = j;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic xv, input logic xb, input logic ov,
                        input logic clr, input logic rst);
        logic [31:0] nh;
        int          nhl;
        logic        m;
        x_valid = xv;
        x       = xb;
        overlap = ov;
        clear   = clr;
        reset   = rst;
        for (int d = 0; d < 3; d++) begin
            e_y[d] = 0;
            if (!rst || clr) begin
                m_h[d]   = '0;
                m_hl[d]  = 0;
                m_cnt[d] = 0;
            end else if (xv) begin
                nh  = {m_h[d][30:0], xb};
                nhl = (m_hl[d] < 32) ? m_hl[d] + 1 : 32;
                m   = ends_with(nh, nhl, m_pat[d], m_len[d], m_len[d]);
                e_y[d] = m ? 1 : 0;
                if (m && m_cnt[d] < m_max[d]) m_cnt[d]++;
                if (m && !ov) begin
                    m_h[d]  = '0;
                    m_hl[d] = 0;
                end else begin
                    m_h[d]  = nh;
                    m_hl[d] = nhl;
                end
            end
            e_ns[d] = model_state(m_h[d], m_hl[d], m_pat[d], m_len[d]);
        end
        #2;
        chk("y_a", 32'(y_a), 32'(e_y[0]));
        chk("y_b", 32'(y_b), 32'(e_y[1]));
        chk("y_c", 32'(y_c), 32'(e_y[2]));
        chk("next_a", 32'(ns_a), 32'(e_ns[0]));
        chk("next_b", 32'(ns_b), 32'(e_ns[1]));
        chk("next_c", 32'(ns_c), 32'(e_ns[2]));
        @(posedge clk);
        #1;
        chk("state_a", 32'(cs_a), 32'(e_ns[0]));
        chk("state_b", 32'(cs_b), 32'(e_ns[1]));
        chk("state_c", 32'(cs_c), 32'(e_ns[2]));
        chk("count_a", 32'(hc_a), 32'(m_cnt[0]));
        chk("count_b", 32'(hc_b), 32'(m_cnt[1]));
        chk("count_c", 32'(hc_c), 32'(m_cnt[2]));
    endtask

    task automatic send(input logic [31:0] bits, input int n, input logic ov);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], ov, 1'b0, 1'b1);
    endtask

    initial begin
        logic rv, cv, vv, bv, ov;

        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("reset_count", 32'(hc_a), 32'd0);

        // Overlapping: 1011011 matches twice
        send(32'b1011, 4, 1'b1);
        chk("t1_state_after_match", 32'(cs_a), 32'd1);
        send(32'b011, 3, 1'b1);
        chk("t1_hits", 32'(hc_a), 32'd2);

        // Non-overlapping: only the first match counts
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send(32'b1011011, 7, 1'b0);
        chk("t2_hits", 32'(hc_a), 32'd1);
        chk("t2_state", 32'(cs_a), 32'd1);

        // Valid gaps with x toggling while invalid
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("t3_hits", 32'(hc_a), 32'd1);

        // Clear coinciding with the matching bit
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        send(32'b101, 3, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("t4_hits", 32'(hc_a), 32'd0);
        chk("t4_state", 32'(cs_a), 32'd0);

        // Reset mid-pattern drops the partial match
        send(32'b101, 3, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        send(32'b1011, 4, 1'b1);
        chk("t5_hits", 32'(hc_a), 32'd1);

        // Saturation of the 2-bit counter, then 111 detector on a run of ones
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        send(32'b1011011011011011, 16, 1'b1);
        chk("t6_sat", 32'(hc_b), 32'd3);
        chk("t6_nosat", 32'(hc_a), 32'd5);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        send(32'b111111, 6, 1'b1);
        chk("t6_ones", 32'(hc_c), 32'd4);

        ov = 1'b1;
        for (int i = 0; i < 600; i++) begin
            rv = ($urandom_range(0, 99) >= 2);
            cv = ($urandom_range(0, 99) < 3);
            vv = ($urandom_range(0, 99) < 75);
            bv = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) ov = ~ov;
            step(vv, bv, ov, cv, rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_detect_fsm.md
Name: seq_detect_fsm

Overview:
Parametrised Mealy sequence-detector FSM. It watches a serial bit stream `x`, qualified by `x_valid`, and recognises a PATTERN_LEN-bit pattern given as a parameter. Overlapping or non-overlapping match mode is selectable at run time. It pulses `y` on each match, keeps a saturating hit counter, and exposes current and next state for debug. It replaces the hand-enumerated five-state detector FSMs in the lab designs.

Parameters:
- PATTERN_LEN, 4, pattern length in bits; legal 2..16; any other value is an elaboration error.
- PATTERN, 4'b1011, pattern value; bit PATTERN_LEN-1 is received first (MSB-first).
- CNT_W, 8, width of hit_count; legal 1..32.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- x  in  1  serial data bit.
- x_valid  in  1  x is sampled this cycle only when high.
- overlap  in  1  1 = overlapping matches allowed; 0 = restart after each match.
- clear  in  1  synchronous clear of state and counter.
- y  out  1  Mealy match pulse (combinational).
- hit_count  out  CNT_W  registered count of matches; saturates.
- currentState  out  STATE_W  registered state, where STATE_W = max(1, clog2(PATTERN_LEN)).
- nextState  out  STATE_W  combinational next state.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-low on `reset`, sampled at the rising edge of `clk`.
- State meaning: state k (0..PATTERN_LEN-1) = the length of the longest pattern prefix that is also a suffix of the accepted bits, with k < PATTERN_LEN.
- Transition on an accepted bit b (x_valid=1):
  - Form the string prefix(k) followed by b.
  - If k = PATTERN_LEN-1 and b = PATTERN[0], this is a match:
    - y = 1.
    - If overlap=1, next state = length of the longest proper border of the full pattern.
    - If overlap=0, next state = 0.
  - Otherwise, next state = the longest prefix of the pattern that is a suffix of that string (KMP failure rule).
- Transition table: computed at elaboration from PATTERN. No run-time table storage.
- x_valid=0: next state = current state, y = 0, counter holds.
- Output y: y = x_valid & match & reset & ~clear. Zero-cycle latency from x. Exactly one cycle high per match.
- Counter: hit_count increments by 1 at the clock edge of each cycle where y=1. Once it is all-ones it holds (no wrap).
- Clear:
  - When clear=1 (and reset high), currentState <= 0 and hit_count <= 0.
  - Clear has priority over x_valid; a bit arriving in the same cycle is discarded.
- Reset:
  - When reset=0 at an edge, currentState <= 0 and hit_count <= 0.
  - While reset=0: y = 0 and nextState = 0.
  - Reset mid-pattern drops the partial match.
  - Reset has priority over clear.
- Run-time mode change: overlap is sampled only in a match cycle. Changing it between matches takes effect at the next match.
- Illegal state: any currentState value ≥ PATTERN_LEN (only possible when PATTERN_LEN is not a power of 2) has next state 0 and y = 0.
- Debug port: nextState equals the value currentState will take at the next edge, including reset and clear effects.

Decomposition:
- Package `seq_det_pkg`:
  - STATE_W helper function.
  - Constant function next_prefix(pattern, len, k, b) returning the KMP next state.
  - Constant function border_len(pattern, len).
- seq_detect_fsm builds its transition constants from these at elaboration.
- Sub-module `sat_counter` (parameter W; ports clk, reset, clear, inc, count) holds the saturating hit counter.
- State register and next-state/y logic stay in seq_detect_fsm.

Test Plan:
1. Overlap match: defaults, overlap=1, x_valid=1, stream 1,0,1,1,0,1,1 -> y high on bits 4 and 7; hit_count=2; currentState after bit 4 = 1.
2. Non-overlap match: same stream with overlap=0 -> y high only on bit 4; hit_count=1; currentState after bit 7 = 1.
3. Valid gaps: stream 1,0,1,1 with x_valid=0 cycles inserted (x toggling during them) -> state holds through the gaps; single y pulse on the 4th valid bit; y=0 on every invalid cycle.
4. Clear during match: clear=1 on the cycle of the matching 4th bit -> y=0; hit_count unchanged from 0; currentState=0 next cycle.
5. Reset mid-pattern: reset=0 for one edge after 1,0,1 -> currentState=0, nextState=0, y=0 during reset; a following 1 does not match; full 1,0,1,1 then gives hit_count=1.
6. Saturation and alternate parameters:
   - CNT_W=2, five back-to-back overlapping matches of 1011 -> hit_count reads 1,2,3,3,3.
   - PATTERN_LEN=3, PATTERN=3'b111, overlap=1, six 1s -> y on bits 3,4,5,6.
